// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a programmable
// number of wait states between request accept and RAM access. Word-addressed
// 32-bit RAM with byte-enable stores; results returned over a valid/ready channel.
module dmem_responder #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned WAIT_CYC = 2   // legal range 0..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYC);
  localparam bit          NoWait   = (WAIT_CYC == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [Depth];

  logic              do_access;
  logic              acc_wen;
  logic [31:0]       acc_addr, acc_wdata;
  logic [3:0]        acc_be;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       old_word, merged_word;
  logic              mem_we;

  // Access operands: with zero wait states the access happens on the accept edge,
  // so it must use the live request instead of the latched copy.
  always_comb begin
    acc_wen   = wen_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == StIdle) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  // Address decode, range/alignment check and byte merge against the stored word.
  always_comb begin
    acc_idx  = acc_addr[ADDR_W+1:2];
    acc_err  = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
    old_word = mem[acc_idx];
    for (int i = 0; i < 4; i++) begin
      merged_word[8*i +: 8] = acc_be[i] ? acc_wdata[8*i +: 8] : old_word[8*i +: 8];
    end
  end

  // Next-state logic, wait-state counter and response capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (NoWait) begin
            do_access = 1'b1;
            state_d   = StResp;
          end else begin
            cnt_d   = WaitInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (do_access) begin
      err_d   = acc_err;
      rdata_d = acc_err ? 32'd0 : (acc_wen ? merged_word : old_word);
    end
  end

  assign mem_we    = do_access && acc_wen && !acc_err;
  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // FSM, counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture; inputs are only looked at on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else if (state_q == StIdle && req_valid) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // RAM array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYC=2 instance (a_*) and a
// WAIT_CYC=0 instance (b_*) sharing clock and reset.
module tb_dmem_responder;

  logic clk;
  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_wen, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  logic        b_req_valid, b_req_ready, b_req_wen, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int n_chk = 0;
  int n_bad = 0;

  dmem_responder #(.ADDR_W(9), .WAIT_CYC(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(a_req_wen),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err)
  );

  dmem_responder #(.ADDR_W(9), .WAIT_CYC(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (sel == 0) begin
      a_req_valid = v; a_req_wen = wen; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    end else begin
      b_req_valid = v; b_req_wen = wen; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
    end
  endtask

  // Entered at a negedge with the target idle and rsp_ready high; lat counts
  // negedges from the request until rsp_valid is seen (capped at 20).
  task automatic run_xact(input int sel, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err, output int lat);
    drive(sel, 1'b1, wen, addr, wdata, be);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    lat = 1;
    while (!((sel == 0) ? a_rsp_valid : b_rsp_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = (sel == 0) ? a_rsp_rdata : b_rsp_rdata;
    err   = (sel == 0) ? a_rsp_err : b_rsp_err;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          k;

  initial begin
    rst_n = 1'b0;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 32'(a_req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check_eq("rst_rdata", a_rsp_rdata, 32'd0);
    check_eq("rst_err", 32'(a_rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full store then load
    run_xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check_eq("st_full_lat", 32'(lat), 32'd3);
    check_eq("st_full_rdata", rd, 32'hDEADBEEF);
    check_eq("st_full_err", 32'(er), 32'd0);
    run_xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_eq("ld_full_rdata", rd, 32'hDEADBEEF);

    // Partial store
    run_xact(0, 1'b1, 32'h10, 32'h00001234, 4'b0011, rd, er, lat);
    check_eq("st_part_rdata", rd, 32'hDEAD1234);
    run_xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_eq("ld_part_rdata", rd, 32'hDEAD1234);

    // Errors: misaligned, out of range, misaligned store with no side effect
    run_xact(0, 1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
    check_eq("mis_err", 32'(er), 32'd1);
    check_eq("mis_rdata", rd, 32'd0);
    run_xact(0, 1'b0, 32'h800, 32'h0, 4'h0, rd, er, lat);
    check_eq("oor_err", 32'(er), 32'd1);
    check_eq("oor_rdata", rd, 32'd0);
    run_xact(0, 1'b1, 32'h11, 32'h0, 4'hF, rd, er, lat);
    check_eq("mis_st_err", 32'(er), 32'd1);
    run_xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check_eq("post_err_rdata", rd, 32'hDEAD1234);
    check_eq("post_err_err", 32'(er), 32'd0);

    // be=0 store returns old word; last word in range
    run_xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    check_eq("be0_rdata", rd, 32'hDEAD1234);
    run_xact(0, 1'b1, 32'h7FC, 32'h5A5A5A5A, 4'hF, rd, er, lat);
    run_xact(0, 1'b0, 32'h7FC, 32'h0, 4'h0, rd, er, lat);
    check_eq("top_word_rdata", rd, 32'h5A5A5A5A);
    check_eq("top_word_err", 32'(er), 32'd0);

    // Back-pressure with a second request waiting
    run_xact(0, 1'b1, 32'h14, 32'h01020304, 4'hF, rd, er, lat);
    a_rsp_ready = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    k = 1;
    while (!a_rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("bp_lat", 32'(k), 32'd3);
    check_eq("bp_rdata0", a_rsp_rdata, 32'hDEAD1234);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_hold_valid", 32'(a_rsp_valid), 32'd1);
      check_eq("bp_hold_rdata", a_rsp_rdata, 32'hDEAD1234);
      check_eq("bp_hold_ready", 32'(a_req_ready), 32'd0);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_after_hs_ready", 32'(a_req_ready), 32'd1);
    check_eq("bp_after_hs_valid", 32'(a_rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("bp_second_accepted", 32'(a_req_ready), 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    k = 1;
    while (!a_rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("bp_second_lat", 32'(k), 32'd3);
    check_eq("bp_second_rdata", a_rsp_rdata, 32'h01020304);
    @(negedge clk);

    // Reset during WAIT drops the pending store
    run_xact(0, 1'b1, 32'h20, 32'h22222222, 4'hF, rd, er, lat);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h11111111, 4'hF);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check_eq("wait_ready_low", 32'(a_req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_req_ready", 32'(a_req_ready), 32'd1);
    check_eq("arst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check_eq("arst_rdata", a_rsp_rdata, 32'd0);
    check_eq("arst_err", 32'(a_rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_xact(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check_eq("arst_ld_rdata", rd, 32'h22222222);

    // Zero-wait instance: latency 1, back-to-back loads every 2 cycles
    run_xact(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, er, lat);
    check_eq("w0_st_lat", 32'(lat), 32'd1);
    check_eq("w0_st_rdata", rd, 32'hCAFEF00D);
    run_xact(1, 1'b1, 32'h44, 32'h0BADC0DE, 4'hF, rd, er, lat);
    run_xact(1, 1'b0, 32'h42, 32'h0, 4'h0, rd, er, lat);
    check_eq("w0_mis_err", 32'(er), 32'd1);
    drive(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    @(negedge clk);
    check_eq("w0_b2b_valid0", 32'(b_rsp_valid), 32'd1);
    check_eq("w0_b2b_ready0", 32'(b_req_ready), 32'd0);
    check_eq("w0_b2b_rdata0", b_rsp_rdata, 32'hCAFEF00D);
    drive(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    @(negedge clk);
    check_eq("w0_b2b_gap_valid", 32'(b_rsp_valid), 32'd0);
    check_eq("w0_b2b_gap_ready", 32'(b_req_ready), 32'd1);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check_eq("w0_b2b_valid1", 32'(b_rsp_valid), 32'd1);
    check_eq("w0_b2b_rdata1", b_rsp_rdata, 32'h0BADC0DE);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
